// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and parity mode constants
// Contents:
//   tx_state_t : frame FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   PAR_*      : parity_mode encodings (11 is treated like PAR_NONE)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word fall-through synchronous FIFO for the UART transmitter
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request and word (ignored while full)
//   pop           : remove head word (ignored while empty)
//   rdata         : head word, valid whenever empty is low
//   full, empty   : occupancy flags
//   level         : current occupancy, 0..DEPTH
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; the level counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      level <= level + LVL_ONE;
      else if (!do_push && do_pop) level <= level - LVL_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - UART transmitter with valid/ready byte-stream input and input FIFO
// Optional feature macro: UART_TX_PARITY_EN (parity bit from parity_mode; otherwise frames are parity-less)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   s_valid      : input word valid
//   s_ready      : FIFO can accept a word (not full)
//   s_data       : input word, DATA_BITS wide
//   parity_mode  : 00 none, 01 even, 10 odd, 11 none (sampled when a frame starts)
//   tx           : serial line, idle high (registered)
//   busy         : frame in progress or FIFO non-empty
//   tx_done      : one-cycle pulse during the last cycle of a frame's final stop bit (registered)
//   state        : FSM state for debug
//   fifo_level   : FIFO occupancy
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [2:0]                    state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW   = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int BITW = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   STOP_LAST = BW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
  localparam logic [BITW-1:0] DATA_LAST = BITW'(DATA_BITS - 1);
  localparam logic [BITW-1:0] BITC_ONE  = BITW'(1);

  tx_state_t            state_q;
  tx_state_t            state_next;
  logic [BW-1:0]        baud_cnt;
  logic [BW-1:0]        baud_next;
  logic [BITW-1:0]      bit_cnt;
  logic [BITW-1:0]      bit_next;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 parity_en;
  logic                 par_bit;
  logic                 tx_next;
  logic                 done_next;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  // Mode is captured with the word so mid-frame changes on the port cannot corrupt the frame.
  logic [1:0] mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      mode_q <= PAR_NONE;
    else if (pop) mode_q <= parity_mode;
  end

  assign parity_en = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
  assign par_bit   = (mode_q == PAR_ODD) ? ~^data_q : ^data_q;
`else
  logic unused_parity;

  assign unused_parity = ^parity_mode;
  assign parity_en     = 1'b0;
  assign par_bit       = 1'b1;
`endif

  // State register; tx and tx_done are registered from the next-state view so the
  // line changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      tx       <= tx_next;
      tx_done  <= done_next;
      if (pop) data_q <= fifo_head;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    baud_next  = baud_cnt + BAUD_ONE;
    bit_next   = bit_cnt;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BIT_LAST) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = parity_en ? PARITY : STOP;
          end else begin
            bit_next = bit_cnt + BITC_ONE;
          end
        end
      end
      PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          state_next = STOP;
          baud_next  = '0;
        end
      end
      STOP: begin
        if (baud_cnt == STOP_LAST) begin
          baud_next = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Output logic: values the registered outputs take after this edge.
  always_comb begin
    tx_next   = 1'b1;
    done_next = 1'b0;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[bit_next];
      PARITY:  tx_next = par_bit;
      STOP: begin
        tx_next   = 1'b1;
        done_next = (baud_next == STOP_LAST);
      end
      default: tx_next = 1'b1;
    endcase
  end

  assign s_ready = !fifo_full;
  assign busy    = (state_q != IDLE) || (fifo_level != '0);
  assign state   = state_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - self-checking bench for uart_tx_stream (default and 7-bit/2-stop/4-clk builds)
module tb_uart_tx_stream;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       sv_a, ready_a, tx_a, busy_a, done_a;
  logic [7:0] sd_a;
  logic [1:0] pm_a;
  logic [2:0] st_a, lvl_a;

  logic       sv_b, ready_b, tx_b, busy_b, done_b;
  logic [6:0] sd_b;
  logic [1:0] pm_b;
  logic [2:0] st_b, lvl_b;

  uart_tx_stream dut_a (
    .clk(clk), .rst(rst), .s_valid(sv_a), .s_ready(ready_a), .s_data(sd_a),
    .parity_mode(pm_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a),
    .state(st_a), .fifo_level(lvl_a)
  );

  uart_tx_stream #(.DATA_BITS(7), .CLKS_PER_BIT(4), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(ready_b), .s_data(sd_b),
    .parity_mode(pm_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b),
    .state(st_b), .fifo_level(lvl_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int cq [2][$];     // expected per-cycle line activity of the frame in flight
  int wq [2][$];     // words accepted but not yet started
  int cur [2];       // expected outputs for the current cycle
  int done_n [2];
  int done_t [2][$];

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int enc(input int t, input int d, input int s);
    return t | (d << 1) | (s << 2);
  endfunction

  // One clock of the model: a frame is expanded bit by bit into cycles when it starts.
  task automatic model_step(input int i, input bit v, input int d, input int m);
    int db, cpb, sb, pre, w;
    bit par;
    if (i == 0) begin db = 8; cpb = 16; sb = 1; end
    else        begin db = 7; cpb = 4;  sb = 2; end
    pre = wq[i].size();
    if (cq[i].size() == 0 && pre != 0) begin
      w = wq[i].pop_front();
      repeat (cpb) cq[i].push_back(enc(0, 0, 1));
      for (int b = 0; b < db; b++) repeat (cpb) cq[i].push_back(enc((w >> b) & 1, 0, 2));
      if (PAR_EN && (m == 1 || m == 2)) begin
        par = 1'b0;
        for (int b = 0; b < db; b++) par = par ^ bit'((w >> b) & 1);
        if (m == 2) par = !par;
        repeat (cpb) cq[i].push_back(enc(int'(par), 0, 3));
      end
      for (int k = 0; k < sb * cpb; k++) cq[i].push_back(enc(1, (k == sb * cpb - 1) ? 1 : 0, 4));
    end
    if (cq[i].size() != 0) cur[i] = cq[i].pop_front();
    else cur[i] = enc(1, 0, 0);
    if (v && pre < 4) wq[i].push_back(d);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          cq[i].delete();
          wq[i].delete();
          cur[i] = enc(1, 0, 0);
        end
      end else begin
        cyc++;
        model_step(0, sv_a, int'(sd_a), int'(pm_a));
        model_step(1, sv_b, int'(sd_b), int'(pm_b));
      end
    end
  end

  task automatic check_inst(input int i, input logic t, input logic d, input logic [2:0] s,
                            input logic [2:0] l, input logic r, input logic b);
    int e;
    e = cur[i];
    chk($sformatf("tx[%0d]", i), int'(t), e & 1);
    chk($sformatf("tx_done[%0d]", i), int'(d), (e >> 1) & 1);
    chk($sformatf("state[%0d]", i), int'(s), e >> 2);
    chk($sformatf("level[%0d]", i), int'(l), wq[i].size());
    chk($sformatf("s_ready[%0d]", i), int'(r), (wq[i].size() < 4) ? 1 : 0);
    chk($sformatf("busy[%0d]", i), int'(b), ((e >> 2) != 0 || wq[i].size() != 0) ? 1 : 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_inst(0, tx_a, done_a, st_a, lvl_a, ready_a, busy_a);
        check_inst(1, tx_b, done_b, st_b, lvl_b, ready_b, busy_b);
        if (done_a) begin done_n[0]++; done_t[0].push_back(cyc); end
        if (done_b) begin done_n[1]++; done_t[1].push_back(cyc); end
      end
    end
  end

  task automatic push_a(input logic [7:0] d, input logic [1:0] m);
    sv_a = 1'b1; sd_a = d; pm_a = m;
    @(negedge clk);
    sv_a = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) break;
    end
    chk("idle_timeout", (c >= 2000) ? 1 : 0, 0);
  endtask

  initial begin
    logic [9:0] f1;
    logic [7:0] w3 [6];
    int n0, s0, idx, full_lvl;
    bit saw_full, reopened, acc;

    sv_a = 0; sd_a = 0; pm_a = 0; sv_b = 0; sd_b = 0; pm_b = 0;
    done_n[0] = 0; done_n[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_state", st_a, 0);
    chk("rst_level", lvl_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_done", done_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, no parity: start, 1,0,1,0,0,1,0,1, stop
    f1 = 10'b1_1010_0101_0;
    n0 = done_n[0];
    push_a(8'hA5, 2'b00);
    @(negedge clk);
    chk("t1_fall", tx_a, 0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_bit%0d", k), tx_a, f1[k]);
      repeat (16) @(negedge clk);
    end
    chk("t1_done_cnt", done_n[0] - n0, 1);
    chk("t1_busy_after", busy_a, 0);

    // three back-to-back frames, done pulses 160 cycles apart
    n0 = done_n[0];
    sv_a = 1; sd_a = 8'h55; @(negedge clk);
    sd_a = 8'h0F; @(negedge clk);
    sd_a = 8'h80; @(negedge clk);
    sv_a = 0;
    wait_idle();
    chk("t2_done_cnt", done_n[0] - n0, 3);
    chk("t2_gap1", done_t[0][done_t[0].size()-1] - done_t[0][done_t[0].size()-2], 160);
    chk("t2_gap2", done_t[0][done_t[0].size()-2] - done_t[0][done_t[0].size()-3], 160);

    // six words with s_valid held: back-pressure at level 4
    w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33; w3[3] = 8'h44; w3[4] = 8'hC5; w3[5] = 8'h6E;
    n0 = done_n[0]; idx = 0; saw_full = 0; reopened = 0; full_lvl = -1;
    sv_a = 1; sd_a = w3[0];
    for (int c = 0; c < 3000 && idx < 6; c++) begin
      if (!ready_a && !saw_full) begin saw_full = 1; full_lvl = int'(lvl_a); end
      if (ready_a && saw_full) reopened = 1;
      acc = ready_a;
      @(negedge clk);
      if (acc) idx++;
      if (idx < 6) sd_a = w3[idx];
      else sv_a = 0;
    end
    sv_a = 0;
    chk("t3_accepted", idx, 6);
    chk("t3_saw_full", saw_full, 1);
    chk("t3_full_level", full_lvl, 4);
    chk("t3_reopened", reopened, 1);
    wait_idle();
    chk("t3_done_cnt", done_n[0] - n0, 6);

    // 0x07 even then odd; parity_mode changed after the frame has started
    push_a(8'h07, 2'b01);
    @(negedge clk);
    s0 = cyc;
    pm_a = 2'b10;
    repeat (8 + 16 * 9) @(negedge clk);
    chk("t4_even_bit", tx_a, PAR_EN ? 1 : 1);
    wait_idle();
    chk("t4_even_len", done_t[0][done_t[0].size()-1] - s0, PAR_EN ? 175 : 159);
    push_a(8'h07, 2'b10);
    @(negedge clk);
    s0 = cyc;
    pm_a = 2'b01;
    repeat (8 + 16 * 9) @(negedge clk);
    chk("t4_odd_bit", tx_a, PAR_EN ? 0 : 1);
    wait_idle();
    chk("t4_odd_len", done_t[0][done_t[0].size()-1] - s0, PAR_EN ? 175 : 159);
    pm_a = 2'b00;

    // 7 data bits, 2 stop bits, 4 clocks per bit: 40-cycle frame
    sv_b = 1; sd_b = 7'h7F; @(negedge clk);
    sv_b = 0;
    s0 = cyc;
    @(negedge clk);
    chk("t5_fall", tx_b, 0);
    wait_idle();
    chk("t5_done_cnt", done_n[1], 1);
    chk("t5_len", done_t[1][done_t[1].size()-1] - s0, 40);

    // reset 30 cycles into a frame with words queued
    sv_a = 1; sd_a = 8'h3C; @(negedge clk);
    sd_a = 8'h5A; @(negedge clk);
    sd_a = 8'h96; @(negedge clk);
    sv_a = 0;
    repeat (28) @(negedge clk);
    n0 = done_n[0];
    rst = 1'b1;
    #1;
    chk("t6_tx", tx_a, 1);
    chk("t6_level", lvl_a, 0);
    chk("t6_state", st_a, 0);
    chk("t6_busy", busy_a, 0);
    chk("t6_ready", ready_a, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_done", done_n[0] - n0, 0);
    push_a(8'hC3, 2'b00);
    wait_idle();
    chk("t6_clean_frame", done_n[0] - n0, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
